// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the NPU multi-channel memory arbiter.
// mem_req_t is sized to the system memory bus widths below.
package npu_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam int ST_BUSY       = 0;
  localparam int ST_ERR_ORPHAN = 1;
  localparam int ST_TAGS_EMPTY = 2;
  localparam int ST_TAGS_FULL  = 3;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  we;
    logic                  re;
  } mem_req_t;

  function automatic int ch_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_mem_arbiter_if.sv
// Channel-side request/return bus plus the shared DDR port of the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface npu_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CH_COUNT   = 4
);
  logic [CH_COUNT*ADDR_WIDTH-1:0] ch_addr;
  logic [CH_COUNT*DATA_WIDTH-1:0] ch_wdata;
  logic [CH_COUNT-1:0]            ch_we;
  logic [CH_COUNT-1:0]            ch_re;
  logic [CH_COUNT-1:0]            ch_ready;
  logic [DATA_WIDTH-1:0]          ch_rdata;
  logic [CH_COUNT-1:0]            ch_valid;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [DATA_WIDTH-1:0]          mem_wdata;
  logic [DATA_WIDTH-1:0]          mem_rdata;
  logic                           mem_we;
  logic                           mem_re;
  logic                           mem_valid;
  logic [3:0]                     status;
  logic [CH_COUNT*16-1:0]         stat_grants;

  modport slave (
    input  ch_addr, ch_wdata, ch_we, ch_re, mem_rdata, mem_valid,
    output ch_ready, ch_rdata, ch_valid, mem_addr, mem_wdata, mem_we, mem_re,
           status, stat_grants
  );

  modport master (
    output ch_addr, ch_wdata, ch_we, ch_re, mem_rdata, mem_valid,
    input  ch_ready, ch_rdata, ch_valid, mem_addr, mem_wdata, mem_we, mem_re,
           status, stat_grants
  );
endinterface

// File: rtl/npu_tag_fifo.sv
// Synchronous FIFO of channel IDs for in-flight reads; DEPTH must be a power of 2.
module npu_tag_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_id,
  input  logic             i_pop,
  output logic [ID_W-1:0]  o_id,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_id    = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/npu_mem_arbiter.sv
// Round-robin arbiter sharing one DDR port among CH_COUNT channels with in-order read return.
// Define NPU_MEM_ARB_STATS_EN to build the per-channel saturating grant counters.
module npu_mem_arbiter
  import npu_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = MEM_DATA_W,
  parameter int ADDR_WIDTH      = MEM_ADDR_W,
  parameter int CH_COUNT        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic              clk,
  input logic              rst,
  npu_mem_arbiter_if.slave bus
);
  localparam int CH_ID_W = ch_id_w(CH_COUNT);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;

  logic [CH_COUNT-1:0] w_req;
  logic [CH_COUNT-1:0] w_elig;
  logic [CH_COUNT-1:0] w_grant;
  logic [CH_ID_W-1:0]  w_win;
  logic                w_any;
  logic [CH_ID_W-1:0]  r_last_grant;
  mem_req_t            w_sel;
  mem_req_t            r_issue;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [CH_ID_W-1:0]  w_head;
  logic                w_push;
  logic                w_pop;
  logic [CH_COUNT-1:0] r_ch_valid;
  logic [DATA_WIDTH-1:0] r_ch_rdata;
  logic                r_err_orphan;
  logic [3:0]          w_status;

  // Reads are skipped while the tag FIFO is full; writes always compete.
  always_comb begin
    w_req  = (bus.ch_we | bus.ch_re) & {CH_COUNT{~rst}};
    w_elig = (bus.ch_we | (bus.ch_re & {CH_COUNT{~w_full}})) & {CH_COUNT{~rst}};
  end

  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_any   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    for (int k = 1; k <= CH_COUNT; k++) begin
      v_idx = (int'(r_last_grant) + k) % CH_COUNT;
      if (!w_any && w_elig[v_idx]) begin
        w_any = 1'b1;
        w_win = CH_ID_W'(v_idx);
      end
    end
    if (w_any) w_grant[w_win] = 1'b1;
  end

  always_comb begin
    w_sel = '0;
    if (w_any) begin
      w_sel.addr  = bus.ch_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      w_sel.wdata = bus.ch_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
      w_sel.we    = bus.ch_we[w_win];
      w_sel.re    = bus.ch_re[w_win] & ~bus.ch_we[w_win];
    end
  end

  assign w_push = w_sel.re;
  assign w_pop  = bus.mem_valid & ~w_empty;

  npu_tag_fifo #(
    .ID_W  (CH_ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_id    (w_win),
    .i_pop   (w_pop),
    .o_id    (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Issue stage: winner's request appears on the memory port one cycle after grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue      <= '0;
      r_last_grant <= CH_ID_W'(CH_COUNT - 1);
    end else begin
      r_issue.we <= w_sel.we;
      r_issue.re <= w_sel.re;
      if (w_any) begin
        r_issue.addr  <= w_sel.addr;
        r_issue.wdata <= w_sel.wdata;
        r_last_grant  <= w_win;
      end
    end
  end

  // Return stage: route data to the oldest outstanding tag; unmatched returns are orphans.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_valid   <= '0;
      r_ch_rdata   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_ch_valid <= '0;
      if (w_pop) begin
        r_ch_valid[w_head] <= 1'b1;
        r_ch_rdata         <= bus.mem_rdata;
      end
      if (bus.mem_valid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[ST_TAGS_FULL]  = w_full;
    w_status[ST_TAGS_EMPTY] = w_empty;
    w_status[ST_ERR_ORPHAN] = r_err_orphan;
    w_status[ST_BUSY]       = (|w_req) | (w_count != '0);
  end

  assign bus.ch_ready  = w_grant;
  assign bus.ch_valid  = r_ch_valid;
  assign bus.ch_rdata  = r_ch_rdata;
  assign bus.mem_addr  = r_issue.addr;
  assign bus.mem_wdata = r_issue.wdata;
  assign bus.mem_we    = r_issue.we;
  assign bus.mem_re    = r_issue.re;
  assign bus.status    = w_status;

`ifdef NPU_MEM_ARB_STATS_EN
  for (genvar g = 0; g < CH_COUNT; g++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst)                                r_cnt <= '0;
      else if (w_grant[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign bus.stat_grants[g*16 +: 16] = r_cnt;
  end
`else
  assign bus.stat_grants = '0;
`endif
endmodule
